// File: rtl/shift_add_mul_ctrl_if.sv
// Request/response bundle of the shift-and-add multiplier controller.
interface shift_add_mul_ctrl_if #(
   parameter int unsigned WIDTH = 32
);
   logic                 start;
   logic [WIDTH-1:0]     op_a;
   logic [WIDTH-1:0]     op_b;
   logic                 ready;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (output start, op_a, op_b, input ready, busy, done, product);
   modport slave  (input start, op_a, op_b, output ready, busy, done, product);
endinterface

// File: rtl/shift_add_mul_ctrl.sv
// Sequential 32x32->64 shift-and-add multiplier controller around an external 32-bit adder.
// Optional signed operation is enabled by defining SHIFT_ADD_MUL_SIGNED_EN.
module shift_add_mul_ctrl #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   shift_add_mul_ctrl_if.slave  bus,
   output logic [WIDTH-1:0]     add_a,
   output logic [WIDTH-1:0]     add_b,
   output logic                 add_cin,
   input  logic [WIDTH-1:0]     add_sum,
   input  logic                 add_cout
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_NEG, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     m_q, m_d;
   logic [2*WIDTH-1:0]   p_q, p_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   product_q, product_d;
   logic [WIDTH-1:0]     abs_a, abs_b;
`ifdef SHIFT_ADD_MUL_SIGNED_EN
   logic                 sign_q, sign_d;

   // Magnitudes; -2^31 negates to itself, which reads correctly as unsigned 2^31.
   assign abs_a = bus.op_a[WIDTH-1] ? -bus.op_a : bus.op_a;
   assign abs_b = bus.op_b[WIDTH-1] ? -bus.op_b : bus.op_b;
`else
   assign abs_a = bus.op_a;
   assign abs_b = bus.op_b;
`endif

   assign bus.ready   = (state_q == S_IDLE) || (state_q == S_DONE);
   assign bus.busy    = (state_q == S_RUN) || (state_q == S_NEG);
   assign bus.done    = (state_q == S_DONE);
   assign bus.product = product_q;
   assign add_cin     = 1'b0;

   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      p_d       = p_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      add_a     = '0;
      add_b     = '0;
`ifdef SHIFT_ADD_MUL_SIGNED_EN
      sign_d    = sign_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d = S_RUN;
               m_d     = abs_a;
               p_d     = {{WIDTH{1'b0}}, abs_b};
               cnt_d   = '0;
`ifdef SHIFT_ADD_MUL_SIGNED_EN
               sign_d  = bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
`endif
            end else if (state_q == S_DONE) begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            add_a = p_q[2*WIDTH-1:WIDTH];
            add_b = p_q[0] ? m_q : '0;
            // Adder carry lands in P[63] while the whole accumulator shifts right.
            p_d   = {add_cout, add_sum, p_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH-1)) begin
`ifdef SHIFT_ADD_MUL_SIGNED_EN
               state_d = S_NEG;
`else
               state_d   = S_DONE;
               product_d = p_d;
`endif
            end
         end
`ifdef SHIFT_ADD_MUL_SIGNED_EN
         S_NEG: begin
            product_d = sign_q ? -p_q : p_q;
            state_d   = S_DONE;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         m_q       <= '0;
         p_q       <= '0;
         cnt_q     <= '0;
         product_q <= '0;
`ifdef SHIFT_ADD_MUL_SIGNED_EN
         sign_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         p_q       <= p_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
`ifdef SHIFT_ADD_MUL_SIGNED_EN
         sign_q    <= sign_d;
`endif
      end
   end

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Self-checking bench for shift_add_mul_ctrl with a behavioural adder and product scoreboard.
module tb_shift_add_mul_ctrl;

`ifdef SHIFT_ADD_MUL_SIGNED_EN
   localparam int LAT = 33;
`else
   localparam int LAT = 32;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] add_a, add_b, add_sum;
   logic        add_cin, add_cout;

   always #5 clk = ~clk;

   shift_add_mul_ctrl_if #(.WIDTH(32)) bus ();

   shift_add_mul_ctrl #(.WIDTH(32), .CNT_W(6)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .add_sum  (add_sum),
      .add_cout (add_cout)
   );

   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

   int          errors = 0;
   int          checks = 0;
   int          done_count = 0;
   logic [63:0] exp_q[$];
   logic [63:0] exp_mon;

   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
`ifdef SHIFT_ADD_MUL_SIGNED_EN
      logic signed [63:0] sa, sb;
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      return 64'(sa * sb);
`else
      return {32'd0, a} * {32'd0, b};
`endif
   endfunction

   // Scoreboard and adder-interface monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         checks++;
         if (add_cin !== 1'b0) begin
            errors++;
            $display("FAIL add_cin got=%b want=0", add_cin);
         end
         if (bus.busy !== 1'b1) begin
            checks++;
            if (add_a !== 32'd0 || add_b !== 32'd0) begin
               errors++;
               $display("FAIL add_idle got a=%h b=%h want 0", add_a, add_b);
            end
         end
         if (bus.done === 1'b1) begin
            done_count++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done product=%h", bus.product);
            end else begin
               exp_mon = exp_q.pop_front();
               if (bus.product !== exp_mon) begin
                  errors++;
                  $display("FAIL product got=%h want=%h", bus.product, exp_mon);
               end
            end
         end
      end
   end

   task automatic start_op(input logic [31:0] a, input logic [31:0] b);
      bus.op_a  = a;
      bus.op_b  = b;
      bus.start = 1'b1;
      exp_q.push_back(model(a, b));
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.op_a  = $urandom;
      bus.op_b  = $urandom;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (bus.done !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      if (bus.done !== 1'b1) lat = -1;
   endtask

   task automatic test_reset;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.op_a  = '0;
      bus.op_b  = '0;
      #3;
      checks++;
      if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags got r=%b b=%b d=%b want 1 0 0", bus.ready, bus.busy, bus.done);
      end
      checks++;
      if (bus.product !== 64'd0 || add_a !== 32'd0 || add_b !== 32'd0) begin
         errors++;
         $display("FAIL reset_data got p=%h a=%h b=%h want 0", bus.product, add_a, add_b);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic;
      int lat;
      checks++;
      if (bus.ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_ready got=%b want=1", bus.ready);
      end
      start_op(32'd3, 32'd5);
      checks++;
      if (bus.busy !== 1'b1 || bus.ready !== 1'b0) begin
         errors++;
         $display("FAIL basic_busy got b=%b r=%b want 1 0", bus.busy, bus.ready);
      end
      wait_done(lat);
      checks++;
      if (lat !== LAT) begin
         errors++;
         $display("FAIL basic_latency got=%0d want=%0d", lat, LAT);
      end
      checks++;
      if (bus.product !== 64'h0000_0000_0000_000F) begin
         errors++;
         $display("FAIL basic_product got=%h want=%h", bus.product, 64'hF);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_patterns;
      logic [31:0] pa[4];
      logic [31:0] pb[4];
      logic [63:0] pw[4];
      int lat;
      pa = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 32'hDEAD_BEEF};
      pb = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0002, 32'h1357_9BDF};
      pw = '{64'hFFFF_FFFE_0000_0001, 64'h0, 64'h0000_0001_0000_0000, 64'h0};
      for (int i = 0; i < 4; i++) begin
         start_op(pa[i], pb[i]);
         wait_done(lat);
         checks++;
         if (lat !== LAT) begin
            errors++;
            $display("FAIL pattern%0d_latency got=%0d want=%0d", i, lat, LAT);
         end
`ifndef SHIFT_ADD_MUL_SIGNED_EN
         if (i < 3) begin
            checks++;
            if (bus.product !== pw[i]) begin
               errors++;
               $display("FAIL pattern%0d_const got=%h want=%h", i, bus.product, pw[i]);
            end
         end
`endif
         @(posedge clk); #1;
      end
   endtask

   task automatic test_start_ignored;
      int first = -1;
      int d0;
      d0 = done_count;
      start_op(32'd7, 32'd9);
      for (int k = 1; k <= LAT + 45; k++) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         if (k == 5 || k == 20) begin
            checks++;
            if (bus.ready !== 1'b0 || bus.busy !== 1'b1) begin
               errors++;
               $display("FAIL ignored_ready_k%0d got r=%b b=%b want 0 1", k, bus.ready, bus.busy);
            end
            bus.start = 1'b1;
            bus.op_a  = $urandom;
            bus.op_b  = $urandom;
         end
         if (bus.done === 1'b1 && first < 0) first = k;
      end
      checks++;
      if (first !== LAT) begin
         errors++;
         $display("FAIL ignored_latency got=%0d want=%0d", first, LAT);
      end
      checks++;
      if (done_count - d0 !== 1) begin
         errors++;
         $display("FAIL ignored_done_count got=%0d want=1", done_count - d0);
      end
      checks++;
      if (bus.product !== 64'h3F) begin
         errors++;
         $display("FAIL ignored_product got=%h want=%h", bus.product, 64'h3F);
      end
   endtask

   task automatic test_reset_mid;
      int d0;
      int lat;
      start_op(32'h1234_5678, 32'h0000_5678);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      d0 = done_count;
      exp_q.delete();
      #1;
      checks++;
      if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL midreset_flags got r=%b b=%b d=%b want 1 0 0", bus.ready, bus.busy, bus.done);
      end
      checks++;
      if (bus.product !== 64'd0 || add_a !== 32'd0 || add_b !== 32'd0) begin
         errors++;
         $display("FAIL midreset_data got p=%h a=%h b=%h want 0", bus.product, add_a, add_b);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      checks++;
      if (done_count !== d0) begin
         errors++;
         $display("FAIL midreset_no_done got=%0d want=0", done_count - d0);
      end
      start_op(32'd2, 32'd2);
      wait_done(lat);
      checks++;
      if (lat !== LAT || bus.product !== 64'd4) begin
         errors++;
         $display("FAIL after_reset got lat=%0d p=%h want lat=%0d p=4", lat, bus.product, LAT);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      int k1 = -1;
      int k2 = -1;
      bus.op_a  = 32'h0001_0003;
      bus.op_b  = 32'h0000_0101;
      bus.start = 1'b1;
      exp_q.push_back(model(32'h0001_0003, 32'h0000_0101));
      @(posedge clk); #1;
      bus.op_a = 32'hCAFE_F00D;
      bus.op_b = 32'h0000_0011;
      exp_q.push_back(model(32'hCAFE_F00D, 32'h0000_0011));
      for (int k = 1; k <= 3 * LAT && k2 < 0; k++) begin
         @(posedge clk); #1;
         if (k1 >= 0 && k == k1 + 1) begin
            bus.start = 1'b0;
            bus.op_a  = $urandom;
            bus.op_b  = $urandom;
         end
         if (bus.done === 1'b1) begin
            if (k1 < 0) begin
               k1 = k;
               checks++;
               if (bus.ready !== 1'b1) begin
                  errors++;
                  $display("FAIL b2b_ready got=%b want=1", bus.ready);
               end
            end else begin
               k2 = k;
            end
         end
      end
      bus.start = 1'b0;
      checks++;
      if (k1 !== LAT) begin
         errors++;
         $display("FAIL b2b_first got=%0d want=%0d", k1, LAT);
      end
      checks++;
      if (k2 < 0 || k2 - k1 !== LAT + 1) begin
         errors++;
         $display("FAIL b2b_spacing got=%0d want=%0d", k2 - k1, LAT + 1);
      end
      @(posedge clk); #1;
   endtask

`ifdef SHIFT_ADD_MUL_SIGNED_EN
   task automatic test_signed;
      int lat;
      start_op(32'hFFFF_FFFD, 32'd5);
      wait_done(lat);
      checks++;
      if (lat !== 33 || bus.product !== 64'hFFFF_FFFF_FFFF_FFF1) begin
         errors++;
         $display("FAIL signed_neg got lat=%0d p=%h want 33 %h", lat, bus.product, 64'hFFFF_FFFF_FFFF_FFF1);
      end
      @(posedge clk); #1;
      start_op(32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(lat);
      checks++;
      if (bus.product !== 64'h0000_0000_8000_0000) begin
         errors++;
         $display("FAIL signed_min got=%h want=%h", bus.product, 64'h8000_0000);
      end
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_patterns();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
`ifdef SHIFT_ADD_MUL_SIGNED_EN
      test_signed();
`endif
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d pending want=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
   end

endmodule
